fill_arbiter_nch: RTL

Parametrised miss-fill controller and memory arbiter that sits between NCH cache requestors (channel 0 = D-cache, channel 1 = I-cache in the default build) and the single multicycle main memory. It arbitrates misses with a fixed-priority or round-robin policy and streams a WORDS-word block from memory into the granted cache. It then pulses that cache's tag write. It also passes single-word write-through stores to memory while idle.

---
 rtl/fill_arbiter_nch.sv | 90 +++++++++
 1 files changed

// File: rtl/fill_arbiter_nch.sv
// fill_arbiter_nch: arbitrates NCH cache misses onto one memory and streams block fills back
// Write-through stores bypass arbitration and are served only while idle.
module fill_arbiter_nch #(
    parameter int NCH     = 2,
    parameter int WORDS   = 8,
    parameter int RR_MODE = 0
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NCH-1:0]     miss,
    input  logic [16*NCH-1:0]  miss_addr,
    input  logic               wr_req,
    input  logic [15:0]        wr_addr,
    input  logic [15:0]        wr_data,
    output logic               wr_ack,
    output logic               mem_en,
    output logic               mem_wr,
    output logic [15:0]        mem_addr,
    output logic [15:0]        mem_wdata,
    input  logic [15:0]        mem_rdata,
    input  logic               mem_valid,
    output logic [NCH-1:0]     busy,
    output logic [NCH-1:0]     data_we,
    output logic [15:0]        fill_addr,
    output logic [15:0]        fill_data,
    output logic [NCH-1:0]     tag_we
);
    localparam int CW = $clog2(WORDS) + 1;
    localparam int GW = $clog2(NCH);
    typedef enum logic [1:0] {IDLE, FILL, TAG} state_t;
    state_t state, state_nx;
    logic [GW-1:0] g, ptr, arb, idx;
    logic [15:0] base;
    logic [CW-1:0] issue_cnt, rx_cnt;
    logic any_miss, issuing, rx_ok, last, st, grant;
    logic [NCH-1:0] g_oh;
    // Search from ptr in round-robin mode, from 0 otherwise; first set bit wins.
    always_comb begin
        arb = '0;
        idx = '0;
        any_miss = 1'b0;
        for (int k = 0; k < NCH; k++) begin
            idx = GW'((RR_MODE != 0 ? int'(ptr) + k : k) % NCH);
            if (!any_miss && miss[idx]) begin
                arb = idx;
                any_miss = 1'b1;
            end
        end
    end
    always_comb begin
        st = !rst && state == IDLE && wr_req;
        grant = state == IDLE && !wr_req && any_miss;
        issuing = state == FILL && issue_cnt < CW'(WORDS);
        rx_ok = state == FILL && mem_valid && rx_cnt < CW'(WORDS);
        last = rx_ok && rx_cnt == CW'(WORDS - 1);
        state_nx = state == IDLE ? (grant ? FILL : IDLE) : state == FILL ? (last ? TAG : FILL) : IDLE;
        g_oh = NCH'(1) << g;
        wr_ack = st;
        mem_wr = st;
        mem_en = st || issuing;
        mem_addr = st ? wr_addr : issuing ? base + 16'({issue_cnt, 1'b0}) : '0;
        mem_wdata = rst ? '0 : wr_data;
        busy = state != IDLE ? g_oh : '0;
        data_we = rx_ok ? g_oh : '0;
        fill_addr = rx_ok ? base + 16'({rx_cnt, 1'b0}) : '0;
        fill_data = rx_ok ? mem_rdata : '0;
        tag_we = state == TAG ? g_oh : '0;
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            g <= '0;
            ptr <= '0;
            base <= '0;
            issue_cnt <= '0;
            rx_cnt <= '0;
        end else begin
            state <= state_nx;
            if (grant) begin
                g <= arb;
                base <= miss_addr[16*int'(arb) +: 16] & ~16'(2*WORDS - 1);
                issue_cnt <= '0;
                rx_cnt <= '0;
            end
            if (issuing) issue_cnt <= issue_cnt + CW'(1);
            if (rx_ok) rx_cnt <= rx_cnt + CW'(1);
            if (state == TAG && RR_MODE != 0) ptr <= GW'((int'(g) + 1) % NCH);
        end
    end
endmodule
